phy_rf_wr_ctrl: RTL and testbench

//  Write-side companion to the 100BASE-T1 PHY regfile readers. Accepts 16-bit register write commands
//  for the TOP or PCS regfile (REG1..REG6) and queues them in a small FIFO. Drives the field-split wdata
//  (bits 15:8, 7:4, 1) with a one-hot write strobe, then reads the fields back and retries on mismatch.

---
 rtl/phy_rf_pkg.sv | 51 +++++
 rtl/phy_rf_wr_ctrl_if.sv | 40 ++++
 rtl/phy_rf_cmd_fifo.sv | 66 ++++++
 rtl/phy_rf_wr_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_phy_rf_wr_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_rf_pkg.sv
`default_nettype none
// ============================================================================
//  phy_rf_pkg : shared constants and types for the 100BASE-T1 regfile writer
//  rev 1.0
// ============================================================================
package phy_rf_pkg;

  localparam logic RF_SEL_TOP = 1'b0;
  localparam logic RF_SEL_PCS = 1'b1;

  localparam int NUM_REGS  = 6;
  localparam int FIELD_W   = 13;
  localparam int OFF_F1    = 0;
  localparam int OFF_F7_4  = 1;
  localparam int OFF_F15_8 = 5;
  localparam int CMD_W     = 20;

  localparam logic [1:0] RSP_OK     = 2'b00;
  localparam logic [1:0] RSP_VFAIL  = 2'b01;
  localparam logic [1:0] RSP_BADIDX = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic        sel;
    logic [2:0]  idx;
    logic [15:0] data;
  } cmd_t;

  // Regfile slot layout is {15_8, 7_4, 1}; unstored bits are dropped here.
  function automatic logic [FIELD_W-1:0] pack_fields(input logic [15:0] d);
    logic [FIELD_W-1:0] r;
    r                     = '0;
    r[OFF_F1]             = d[1];
    r[OFF_F7_4 +: 4]      = d[7:4];
    r[OFF_F15_8 +: 8]     = d[15:8];
    return r;
  endfunction

  function automatic logic idx_legal(input logic [2:0] idx);
    return (idx >= 3'd1) && (idx <= 3'd6);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phy_rf_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  phy_rf_wr_ctrl_if : command/response and regfile write bus of the writer
//  rev 1.0
// ============================================================================
interface phy_rf_wr_ctrl_if;
  import phy_rf_pkg::*;

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic                           cmd_sel;
  logic [2:0]                     cmd_idx;
  logic [15:0]                    cmd_data;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [1:0]                     rsp_status;
  logic [2:0]                     rsp_tries;
  logic [7:0]                     wr_f15_8;
  logic [3:0]                     wr_f7_4;
  logic                           wr_f1;
  logic [NUM_REGS-1:0]            top_rf_we;
  logic [NUM_REGS-1:0]            pcs_rf_we;
  logic [NUM_REGS*FIELD_W-1:0]    top_rf_rdata;
  logic [NUM_REGS*FIELD_W-1:0]    pcs_rf_rdata;
  logic [7:0]                     err_cnt;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_idx, cmd_data, rsp_ready, top_rf_rdata, pcs_rf_rdata,
    output cmd_ready, rsp_valid, rsp_status, rsp_tries, wr_f15_8, wr_f7_4, wr_f1,
           top_rf_we, pcs_rf_we, err_cnt
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_idx, cmd_data, rsp_ready, top_rf_rdata, pcs_rf_rdata,
    input  cmd_ready, rsp_valid, rsp_status, rsp_tries, wr_f15_8, wr_f7_4, wr_f1,
           top_rf_we, pcs_rf_we, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/phy_rf_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  phy_rf_cmd_fifo : synchronous command FIFO with registered ready
//  rev 1.0
// ============================================================================
module phy_rf_cmd_fifo
  import phy_rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_full_nxt;

  assign w_push   = i_push & r_ready;
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_pop    = i_pop & ~o_empty;
  assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // Full when the wrap bits differ but the slot addresses coincide.
  assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_ready  <= ~w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/phy_rf_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  phy_rf_wr_ctrl : queued TOP/PCS regfile writer with read-back verify/retry
//  rev 1.0
// ============================================================================
module phy_rf_wr_ctrl
  import phy_rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int VERIFY_DLY = 2,
  parameter int MAX_RETRY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  phy_rf_wr_ctrl_if.slave     bus
);

  localparam int WCW = (VERIFY_DLY > 1) ? $clog2(VERIFY_DLY) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  cmd_t                  r_cmd;
  cmd_t                  w_fifo_cmd;
  logic [CMD_W-1:0]      w_fifo_rdata;
  logic                  w_fifo_empty;
  logic                  w_fifo_ready;
  logic                  w_pop;
  logic                  w_match;
  logic                  w_wait_done;
  logic [3:0]            r_tries;
  logic [WCW-1:0]        r_wait_cnt;
  logic [1:0]            r_status;
  logic [NUM_REGS-1:0]   r_we_top;
  logic [NUM_REGS-1:0]   r_we_pcs;
  logic [NUM_REGS-1:0]   w_we_top_nxt;
  logic [NUM_REGS-1:0]   w_we_pcs_nxt;
  logic [NUM_REGS-1:0]   w_strobe;
  logic [FIELD_W-1:0]    w_rd_slice;
  logic [7:0]            r_f15_8;
  logic [3:0]            r_f7_4;
  logic                  r_f1;
  logic [7:0]            r_err_cnt;

  phy_rf_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.cmd_valid),
    .i_wdata ({bus.cmd_sel, bus.cmd_idx, bus.cmd_data}),
    .o_ready (w_fifo_ready),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty)
  );

  assign w_fifo_cmd  = cmd_t'(w_fifo_rdata);
  assign w_wait_done = (r_wait_cnt == WCW'(VERIFY_DLY - 1));

  always_comb begin
    w_strobe   = '0;
    w_rd_slice = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (r_cmd.idx == 3'(n + 1)) begin
        w_strobe[n] = 1'b1;
        w_rd_slice  = (r_cmd.sel == RF_SEL_PCS) ? bus.pcs_rf_rdata[n*FIELD_W +: FIELD_W]
                                                : bus.top_rf_rdata[n*FIELD_W +: FIELD_W];
      end
    end
  end

  assign w_match = (w_rd_slice == pack_fields(r_cmd.data));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = idx_legal(w_fifo_cmd.idx) ? ST_WRITE : ST_RESP;
        end
      end
      ST_WRITE: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = w_wait_done ? ST_CHECK : ST_WAIT;
      ST_CHECK: begin
        if (w_match) begin
          w_state_nxt = ST_RESP;
        end else if (r_tries <= 4'(MAX_RETRY)) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP:  w_state_nxt = bus.rsp_ready ? ST_IDLE : ST_RESP;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop        = 1'b0;
    w_we_top_nxt = '0;
    w_we_pcs_nxt = '0;
    case (r_state)
      ST_IDLE:  w_pop = ~w_fifo_empty;
      ST_WRITE: begin
        if (r_cmd.sel == RF_SEL_PCS) begin
          w_we_pcs_nxt = w_strobe;
        end else begin
          w_we_top_nxt = w_strobe;
        end
      end
      default: ;
    endcase
  end

  // Strobe and field data are registered, so the strobe lands one cycle after WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd      <= '0;
      r_tries    <= '0;
      r_wait_cnt <= '0;
      r_status   <= RSP_OK;
      r_we_top   <= '0;
      r_we_pcs   <= '0;
      r_f15_8    <= '0;
      r_f7_4     <= '0;
      r_f1       <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_we_top <= w_we_top_nxt;
      r_we_pcs <= w_we_pcs_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cmd    <= w_fifo_cmd;
            r_tries  <= '0;
            r_status <= idx_legal(w_fifo_cmd.idx) ? RSP_OK : RSP_BADIDX;
          end
        end
        ST_WRITE: begin
          r_tries    <= r_tries + 4'd1;
          r_wait_cnt <= '0;
          r_f15_8    <= r_cmd.data[15:8];
          r_f7_4     <= r_cmd.data[7:4];
          r_f1       <= r_cmd.data[1];
        end
        ST_WAIT:  r_wait_cnt <= r_wait_cnt + WCW'(1);
        ST_CHECK: begin
          if (!w_match && (r_tries > 4'(MAX_RETRY))) begin
            r_status <= RSP_VFAIL;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready && (r_status != RSP_OK) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = w_fifo_ready;
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_status = r_status;
  // With MAX_RETRY=7 the attempt count reaches 8; report it clipped to the 3-bit field.
  assign bus.rsp_tries  = (r_tries > 4'd7) ? 3'd7 : r_tries[2:0];
  assign bus.wr_f15_8   = r_f15_8;
  assign bus.wr_f7_4    = r_f7_4;
  assign bus.wr_f1      = r_f1;
  assign bus.top_rf_we  = r_we_top;
  assign bus.pcs_rf_we  = r_we_pcs;
  assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phy_rf_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_phy_rf_wr_ctrl : self-checking bench with a behavioural regfile model
//  rev 1.0
// ============================================================================
module tb_phy_rf_wr_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int VERIFY_DLY = 2;
  localparam int MAX_RETRY  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;

  phy_rf_wr_ctrl_if bus();

  phy_rf_wr_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .VERIFY_DLY (VERIFY_DLY),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Regfile model: a write stores the driven fields, optionally corrupted.
  logic [77:0] top_mem;
  logic [77:0] pcs_mem;
  int          fails_done;
  int          fail_budget = 0;
  bit          stuck74 = 1'b0;
  int          we_pulses;
  int          multi_we;
  logic [5:0]  last_top_we;
  logic [5:0]  last_pcs_we;
  logic [12:0] last_fields;

  assign bus.top_rf_rdata = top_mem;
  assign bus.pcs_rf_rdata = pcs_mem;

  function automatic logic [12:0] stored(input logic [12:0] f, input bit fail, input bit s74);
    logic [12:0] r;
    r = f;
    if (s74)  r[4:1] = 4'h0;
    if (fail) r[0]   = ~r[0];
    return r;
  endfunction

  always @(posedge clk) begin
    if ((bus.top_rf_we | bus.pcs_rf_we) != 6'd0) begin
      for (int n = 0; n < 6; n++) begin
        if (bus.top_rf_we[n])
          top_mem[n*13 +: 13] <= stored({bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1}, fails_done < fail_budget, stuck74);
        if (bus.pcs_rf_we[n])
          pcs_mem[n*13 +: 13] <= stored({bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1}, fails_done < fail_budget, stuck74);
      end
      if (fails_done < fail_budget) fails_done <= fails_done + 1;
    end
  end

  always @(negedge clk) begin
    if ((bus.top_rf_we | bus.pcs_rf_we) != 6'd0) begin
      we_pulses   <= we_pulses + 1;
      last_top_we <= bus.top_rf_we;
      last_pcs_we <= bus.pcs_rf_we;
      last_fields <= {bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1};
      if ($countones({bus.top_rf_we, bus.pcs_rf_we}) != 1) multi_we <= multi_we + 1;
    end
  end

  // Expected {status, tries} from the command rules: each failing write costs one attempt.
  function automatic logic [4:0] exp_rsp(input logic [2:0] idx, input int fails);
    if (idx == 3'd0 || idx == 3'd7) return {2'b10, 3'd0};
    if (fails <= MAX_RETRY)         return {2'b00, 3'(fails + 1)};
    return {2'b01, 3'(MAX_RETRY + 1)};
  endfunction

  function automatic void bump_err(input logic [1:0] st);
    if (st != 2'b00 && exp_err < 255) exp_err = exp_err + 1;
  endfunction

  task automatic send_cmd(input bit sel, input logic [2:0] idx, input logic [15:0] data, output bit ok);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_idx   = idx;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.cmd_ready;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [1:0] st, output logic [2:0] tr, output logic [7:0] ec, output bit ok);
    int n;
    n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.rsp_valid;
    st = bus.rsp_status;
    tr = bus.rsp_tries;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    ec = bus.err_cnt;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: ready=%b rsp_valid=%b required 1/0", bus.cmd_ready, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_status, bus.rsp_tries, bus.err_cnt} !== 13'd0) begin
      errors++; $display("FAIL reset_rsp: status=%b tries=%0d err_cnt=%0d required 0", bus.rsp_status, bus.rsp_tries, bus.err_cnt);
    end
    checks++;
    if ({bus.top_rf_we, bus.pcs_rf_we, bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1} !== 25'd0) begin
      errors++; $display("FAIL reset_wr: we=%h/%h f=%h %h %b required 0", bus.top_rf_we, bus.pcs_rf_we, bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b rsp_valid=%b required 1/0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_single();
    bit ok; logic [1:0] st; logic [2:0] tr; logic [7:0] ec;
    logic [5:0] exp_we;
    fail_budget = fails_done;
    send_cmd(1'b0, 3'd3, 16'hA5F2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: cmd not accepted, required accepted"); end
    for (int k = 1; k <= 3 + VERIFY_DLY; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== (k == 3 + VERIFY_DLY)) begin
        errors++; $display("FAIL single_rsp_timing: cycle N+%0d rsp_valid=%b required %b", k, bus.rsp_valid, k == 3 + VERIFY_DLY);
      end
      exp_we = (k == 2) ? 6'b000100 : 6'b000000;
      checks++;
      if (bus.top_rf_we !== exp_we || bus.pcs_rf_we !== 6'd0) begin
        errors++; $display("FAIL single_we: cycle N+%0d we=%b/%b required %b/000000", k, bus.top_rf_we, bus.pcs_rf_we, exp_we);
      end
      if (k == 2) begin
        checks++;
        if (bus.wr_f15_8 !== 8'hA5 || bus.wr_f7_4 !== 4'hF || bus.wr_f1 !== 1'b1) begin
          errors++; $display("FAIL single_fields: %h %h %b required a5 f 1", bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1);
        end
      end
    end
    get_rsp(st, tr, ec, ok);
    checks++;
    if (!ok || st !== 2'b00 || tr !== 3'd1 || ec !== 8'(exp_err)) begin
      errors++; $display("FAIL single_rsp: ok=%b status=%b tries=%0d err=%0d required 1 00 1 %0d", ok, st, tr, ec, exp_err);
    end
  endtask

  task automatic test_retry();
    bit ok; logic [1:0] st; logic [2:0] tr; logic [7:0] ec; int base;
    base = we_pulses;
    stuck74 = 1'b1;
    send_cmd(1'b1, 3'd6, 16'h3C5A, ok);
    get_rsp(st, tr, ec, ok);
    stuck74 = 1'b0;
    bump_err(2'b01);
    checks++;
    if (!ok || st !== 2'b01 || tr !== 3'd3 || ec !== 8'(exp_err)) begin
      errors++; $display("FAIL retry_rsp: ok=%b status=%b tries=%0d err=%0d required 1 01 3 %0d", ok, st, tr, ec, exp_err);
    end
    checks++;
    if (we_pulses - base !== 3 || last_pcs_we !== 6'b100000 || last_top_we !== 6'd0) begin
      errors++; $display("FAIL retry_strobes: pulses=%0d we=%b/%b required 3 000000/100000", we_pulses - base, last_top_we, last_pcs_we);
    end
  endtask

  task automatic test_bad_idx();
    bit ok; logic [1:0] st; logic [2:0] tr; logic [7:0] ec; int base;
    logic [2:0] bad [2];
    bad[0] = 3'd0; bad[1] = 3'd7;
    base = we_pulses;
    send_cmd(1'b0, bad[0], 16'h1234, ok);
    send_cmd(1'b1, bad[1], 16'h5678, ok);
    for (int i = 0; i < 2; i++) begin
      get_rsp(st, tr, ec, ok);
      bump_err(2'b10);
      checks++;
      if (!ok || st !== 2'b10 || tr !== 3'd0 || ec !== 8'(exp_err)) begin
        errors++; $display("FAIL badidx_rsp%0d: ok=%b status=%b tries=%0d err=%0d required 1 10 0 %0d", i, ok, st, tr, ec, exp_err);
      end
    end
    checks++;
    if (we_pulses !== base) begin
      errors++; $display("FAIL badidx_we: pulses=%0d required 0", we_pulses - base);
    end
  endtask

  task automatic test_backpressure();
    bit ok, rdy; logic [1:0] st; logic [2:0] tr; logic [7:0] ec;
    int acc, n;
    logic [4:0]  expq [$];
    logic [19:0] cmds [6];
    fail_budget = fails_done;
    send_cmd(1'b0, 3'd1, 16'hFFFF, ok);
    expq.push_back(exp_rsp(3'd1, 0));
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 6; i++) begin
      cmds[i] = {1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom)};
      expq.push_back(exp_rsp(cmds[i][18:16], 0));
    end
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_valid = (acc < 6);
      {bus.cmd_sel, bus.cmd_idx, bus.cmd_data} = cmds[(acc < 6) ? acc : 5];
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (acc < 6 && rdy) acc++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (acc !== FIFO_DEPTH || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept: accepted=%0d ready=%b required %0d 0", acc, bus.cmd_ready, FIFO_DEPTH);
    end
    for (int r = 0; r < 7; r++) begin
      get_rsp(st, tr, ec, ok);
      bump_err(expq[0][4:3]);
      checks++;
      if (!ok || {st, tr} !== expq[0] || ec !== 8'(exp_err)) begin
        errors++; $display("FAIL bp_rsp%0d: ok=%b status=%b tries=%0d err=%0d required %b %0d %0d", r, ok, st, tr, ec, expq[0][4:3], expq[0][2:0], exp_err);
      end
      void'(expq.pop_front());
      if (acc < 6) begin
        send_cmd(cmds[acc][19], cmds[acc][18:16], cmds[acc][15:0], ok);
        acc++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [1:0] st; logic [2:0] tr; logic [7:0] ec; int base;
    fail_budget = fails_done;
    send_cmd(1'b0, 3'd2, 16'h1111, ok);
    send_cmd(1'b0, 3'd4, 16'h2222, ok);
    send_cmd(1'b1, 3'd5, 16'h3333, ok);
    rst = 1'b1;
    exp_err = 0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.err_cnt !== 8'd0 ||
        {bus.rsp_status, bus.rsp_tries} !== 5'd0) begin
      errors++; $display("FAIL midrst_rsp: ready=%b rsp_valid=%b err=%0d st=%b tr=%0d required 1 0 0 0 0",
                         bus.cmd_ready, bus.rsp_valid, bus.err_cnt, bus.rsp_status, bus.rsp_tries);
    end
    checks++;
    if ({bus.top_rf_we, bus.pcs_rf_we, bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1} !== 25'd0) begin
      errors++; $display("FAIL midrst_wr: we=%h/%h f=%h %h %b required 0", bus.top_rf_we, bus.pcs_rf_we, bus.wr_f15_8, bus.wr_f7_4, bus.wr_f1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    base = we_pulses;
    bus.rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (we_pulses !== base || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: pulses=%0d rsp_valid=%b required 0 0", we_pulses - base, bus.rsp_valid);
    end
    send_cmd(1'b1, 3'd1, 16'hC3A6, ok);
    get_rsp(st, tr, ec, ok);
    checks++;
    if (!ok || st !== 2'b00 || tr !== 3'd1 || we_pulses - base !== 1 || last_pcs_we !== 6'b000001 ||
        last_fields !== 13'b1100_0011_1010_1) begin
      errors++; $display("FAIL midrst_fresh: ok=%b st=%b tr=%0d pulses=%0d we=%b f=%h required 1 00 1 1 000001 %h",
                         ok, st, tr, we_pulses - base, last_pcs_we, last_fields, 13'b1100_0011_1010_1);
    end
  endtask

  task automatic test_saturate();
    bit ok; logic [1:0] st; logic [2:0] tr; logic [7:0] ec;
    for (int i = 0; i < 300; i++) begin
      send_cmd(1'($urandom), (i % 2 == 0) ? 3'd0 : 3'd7, 16'($urandom), ok);
      get_rsp(st, tr, ec, ok);
      bump_err(2'b10);
      checks++;
      if (!ok || st !== 2'b10 || ec !== 8'(exp_err)) begin
        errors++; $display("FAIL sat_%0d: ok=%b status=%b err=%0d required 1 10 %0d", i, ok, st, ec, exp_err);
      end
    end
    checks++;
    if (bus.err_cnt !== 8'hFF) begin
      errors++; $display("FAIL sat_final: err_cnt=%h required ff", bus.err_cnt);
    end
  endtask

  task automatic test_random();
    bit ok, sel; logic [1:0] st; logic [2:0] tr, idx; logic [7:0] ec; logic [15:0] data;
    logic [4:0] e; logic [5:0] oh; int fails, base;
    rst = 1'b1; exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom); idx = 3'($urandom_range(0, 7)); data = 16'($urandom);
      fails = $urandom_range(0, 3);
      fail_budget = fails_done + fails;
      base = we_pulses;
      e = exp_rsp(idx, fails);
      send_cmd(sel, idx, data, ok);
      repeat ($urandom_range(0, 3) + VERIFY_DLY + 2) @(posedge clk);
      #1;
      get_rsp(st, tr, ec, ok);
      bump_err(e[4:3]);
      checks++;
      if (!ok || {st, tr} !== e || ec !== 8'(exp_err) || we_pulses - base !== int'(e[2:0])) begin
        errors++; $display("FAIL rand_rsp%0d: ok=%b st=%b tr=%0d err=%0d pulses=%0d required %b %0d %0d %0d",
                           i, ok, st, tr, ec, we_pulses - base, e[4:3], e[2:0], exp_err, e[2:0]);
      end
      if (e[2:0] != 3'd0) begin
        oh = 6'd1 << (idx - 3'd1);
        checks++;
        if (last_fields !== {data[15:8], data[7:4], data[1]} ||
            last_top_we !== (sel ? 6'd0 : oh) || last_pcs_we !== (sel ? oh : 6'd0)) begin
          errors++; $display("FAIL rand_wr%0d: f=%h we=%b/%b required %h sel=%b onehot=%b",
                             i, last_fields, last_top_we, last_pcs_we, {data[15:8], data[7:4], data[1]}, sel, oh);
        end
      end
    end
    checks++;
    if (multi_we !== 0) begin
      errors++; $display("FAIL onehot_we: multi-bit strobe cycles=%0d required 0", multi_we);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 1'b0;
    bus.cmd_idx   = 3'd0;
    bus.cmd_data  = 16'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_retry();
    test_bad_idx();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
